// File: rtl/filtro_trepidacao.sv
// Contact-bounce filter: synchronises a raw input and accepts a new level only
// after ESTAVEL consecutive stable cycles, with edge strobes and a rise counter.
module filtro_trepidacao #(
  parameter int ESTAVEL      = 8,
  parameter int LARGURA_CONT = 8
) (
  input  logic                    clkIn,
  input  logic                    clr,
  input  logic                    entrada,
  output logic                    saida,
  output logic                    pulso_sobe,
  output logic                    pulso_desce,
  output logic [LARGURA_CONT-1:0] contagem
);

  localparam int CW = (ESTAVEL > 2) ? $clog2(ESTAVEL) : 1;
  localparam logic [CW-1:0] ALVO = CW'(ESTAVEL - 1);

  typedef enum logic [1:0] {BAIXO, CONF_ALTO, ALTO, CONF_BAIXO} estado_t;

  estado_t       estado;
  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;

  // cnt counts edges that already saw the candidate level; reaching ALVO with
  // the level still present means ESTAVEL consecutive confirmations.
  always_ff @(posedge clkIn or negedge clr) begin
    if (!clr) begin
      s1          <= 1'b0;
      s           <= 1'b0;
      estado      <= BAIXO;
      cnt         <= '0;
      saida       <= 1'b0;
      pulso_sobe  <= 1'b0;
      pulso_desce <= 1'b0;
      contagem    <= '0;
    end else begin
      s1          <= entrada;
      s           <= s1;
      pulso_sobe  <= 1'b0;
      pulso_desce <= 1'b0;
      case (estado)
        BAIXO: begin
          if (s) begin
            estado <= CONF_ALTO;
            cnt    <= CW'(1);
          end
        end
        CONF_ALTO: begin
          if (!s) begin
            estado <= BAIXO;
            cnt    <= '0;
          end else if (cnt == ALVO) begin
            estado     <= ALTO;
            saida      <= 1'b1;
            pulso_sobe <= 1'b1;
            contagem   <= contagem + LARGURA_CONT'(1);
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ALTO: begin
          if (!s) begin
            estado <= CONF_BAIXO;
            cnt    <= CW'(1);
          end
        end
        CONF_BAIXO: begin
          if (s) begin
            estado <= ALTO;
            cnt    <= '0;
          end else if (cnt == ALVO) begin
            estado      <= BAIXO;
            saida       <= 1'b0;
            pulso_desce <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          estado <= BAIXO;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_trepidacao.sv
// Directed bench for filtro_trepidacao: a default instance (ESTAVEL=8) plus a
// 2-bit counter instance used for the wrap-around sequence.
module tb_filtro_trepidacao;

  logic       clkIn;
  logic       clr;
  logic       entrada;
  logic       saida;
  logic       pulso_sobe;
  logic       pulso_desce;
  logic [7:0] contagem;

  logic       entrada2;
  logic       saida2;
  logic       pulso_sobe2;
  logic       pulso_desce2;
  logic [1:0] contagem2;

  int checks;
  int failures;
  int sobeCount;
  int desceCount;
  int sobeCount2;

  filtro_trepidacao #(.ESTAVEL(8), .LARGURA_CONT(8)) dut (
    .clkIn(clkIn), .clr(clr), .entrada(entrada), .saida(saida),
    .pulso_sobe(pulso_sobe), .pulso_desce(pulso_desce), .contagem(contagem)
  );

  filtro_trepidacao #(.ESTAVEL(8), .LARGURA_CONT(2)) dutWrap (
    .clkIn(clkIn), .clr(clr), .entrada(entrada2), .saida(saida2),
    .pulso_sobe(pulso_sobe2), .pulso_desce(pulso_desce2), .contagem(contagem2)
  );

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every cycle passes through here so strobe tallies see each pulse once.
  task automatic tick();
    @(posedge clkIn);
    #1;
    sobeCount  += int'(pulso_sobe);
    desceCount += int'(pulso_desce);
    sobeCount2 += int'(pulso_sobe2);
  endtask

  task automatic applyStimulus(input logic val, input int n);
    entrada = val;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_saida"}, saida, 0);
    checkOutput({tag, "_sobe"}, pulso_sobe, 0);
    checkOutput({tag, "_desce"}, pulso_desce, 0);
    checkOutput({tag, "_cont"}, contagem, 0);
  endtask

  task automatic doReset();
    clr = 1'b0;
    entrada = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    sobeCount = 0; desceCount = 0; sobeCount2 = 0;
    clr = 1'b0; entrada = 1'b0; entrada2 = 1'b0;

    // Reset held for 100 time units while entrada toggles
    for (int i = 0; i < 10; i++) begin
      entrada = i[0];
      tick();
      checkIdle("rst_hold");
    end
    entrada = 1'b0;
    clr = 1'b1;
    applyStimulus(1'b0, 4);
    checkIdle("rst_release");

    // Clean rise: saida rises at edge 9, strobe lasts one cycle
    sobeCount = 0;
    applyStimulus(1'b1, 9);
    checkOutput("rise_e8_saida", saida, 0);
    checkOutput("rise_e8_nopulse", sobeCount, 0);
    tick();
    checkOutput("rise_e9_saida", saida, 1);
    checkOutput("rise_e9_sobe", pulso_sobe, 1);
    checkOutput("rise_e9_desce", pulso_desce, 0);
    checkOutput("rise_e9_cont", contagem, 1);
    tick();
    checkOutput("rise_e10_sobe", pulso_sobe, 0);
    checkOutput("rise_e10_saida", saida, 1);

    // Clean fall: symmetric latency, contagem holds
    desceCount = 0;
    applyStimulus(1'b0, 9);
    checkOutput("fall_e8_saida", saida, 1);
    checkOutput("fall_e8_nopulse", desceCount, 0);
    tick();
    checkOutput("fall_e9_saida", saida, 0);
    checkOutput("fall_e9_desce", pulso_desce, 1);
    checkOutput("fall_e9_sobe", pulso_sobe, 0);
    checkOutput("fall_e9_cont", contagem, 1);
    tick();
    checkOutput("fall_e10_desce", pulso_desce, 0);

    // Bounce: 3-cycle phases for 40 cycles, then hold high
    doReset();
    sobeCount = 0; desceCount = 0;
    for (int i = 0; i < 40; i++) begin
      entrada = ((i / 3) % 2) == 0;
      tick();
    end
    checkOutput("bounce_nopulse", sobeCount + desceCount, 0);
    checkOutput("bounce_saida", saida, 0);
    applyStimulus(1'b1, 9);
    checkOutput("bounce_e8_saida", saida, 0);
    tick();
    checkOutput("bounce_e9_saida", saida, 1);
    checkOutput("bounce_e9_sobe", pulso_sobe, 1);
    checkOutput("bounce_pulses", sobeCount, 1);
    checkOutput("bounce_cont", contagem, 1);

    // Glitch one edge before acceptance restarts the count
    doReset();
    sobeCount = 0;
    applyStimulus(1'b1, 7);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 9);
    checkOutput("glitch_e16_saida", saida, 0);
    checkOutput("glitch_e16_nopulse", sobeCount, 0);
    tick();
    checkOutput("glitch_e17_saida", saida, 1);
    checkOutput("glitch_e17_sobe", pulso_sobe, 1);
    checkOutput("glitch_e17_cont", contagem, 1);

    // Reset mid-confirmation (CONF_ALTO, cnt=5) clears immediately
    applyStimulus(1'b0, 12);
    checkOutput("mid_pre_saida", saida, 0);
    checkOutput("mid_pre_cont", contagem, 1);
    applyStimulus(1'b1, 7);
    clr = 1'b0;
    #1;
    checkIdle("mid_async");
    tick();
    tick();
    clr = 1'b1;
    sobeCount = 0;
    applyStimulus(1'b1, 9);
    checkOutput("mid_e8_saida", saida, 0);
    checkOutput("mid_e8_nopulse", sobeCount, 0);
    tick();
    checkOutput("mid_e9_saida", saida, 1);
    checkOutput("mid_e9_cont", contagem, 1);

    // Wrap-around on the 2-bit instance
    entrada = 1'b0;
    doReset();
    sobeCount2 = 0;
    for (int k = 1; k <= 4; k++) begin
      entrada2 = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      checkOutput($sformatf("wrap_saida_%0d", k), saida2, 1);
      checkOutput($sformatf("wrap_cont_%0d", k), contagem2, k % 4);
      entrada2 = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      checkOutput($sformatf("wrap_low_%0d", k), saida2, 0);
    end
    checkOutput("wrap_pulses", sobeCount2, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
